// File: rtl/mux8_rr_scheduler_pkg.sv
// mux8_rr_scheduler_pkg: shared sizes and FSM state codes for the 8:1 mux scheduler
package mux8_rr_scheduler_pkg;
  localparam int N_SRC = 8;
  localparam int SEL_W = 3;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;
endpackage

// File: rtl/mux8_rr_scheduler_rr_pick8.sv
// rr_pick8: round-robin pick of the first requester after the last grantee
module rr_pick8
  import mux8_rr_scheduler_pkg::*;
(
  input  logic [N_SRC-1:0] req,
  input  logic [SEL_W-1:0] lg,
  output logic             any,
  output logic [SEL_W-1:0] idx
);
  logic [SEL_W-1:0] base;
  logic [SEL_W-1:0] off;
  logic [N_SRC-1:0] rot;
  assign base = lg + 1'b1;
  assign rot  = N_SRC'({req, req} >> base);
  assign any  = |req;
  assign idx  = base + off;
  // lowest set bit of the rotated request vector is the winner's offset from base
  always_comb begin
    off = '0;
    for (int k = N_SRC - 1; k >= 0; k--) off = rot[k] ? SEL_W'(k) : off;
  end
endmodule

// File: rtl/mux8_rr_scheduler.sv
// mux8_rr_scheduler: round-robin grant of the 8:1 mux with bounded hold and break-before-make gap
module mux8_rr_scheduler
  import mux8_rr_scheduler_pkg::*;
#(
  parameter int MAX_HOLD = 4,
  parameter int HOLD_W   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_SRC-1:0] req,
  input  logic             done,
  input  logic [N_SRC-1:0] d,
  output logic [SEL_W-1:0] sel,
  output logic [N_SRC-1:0] gnt,
  output logic             y,
  output logic             y_vld,
  output logic             busy
);
  state_t            state;
  logic [HOLD_W-1:0] hold_cnt;
  logic [SEL_W-1:0]  lg;
  logic              any;
  logic [SEL_W-1:0]  idx;
  logic              expired;
  logic              rel;
  rr_pick8 u_pick (
    .req(req),
    .lg (lg),
    .any(any),
    .idx(idx)
  );
  assign expired = (MAX_HOLD != 0) && (hold_cnt == HOLD_W'(MAX_HOLD));
  assign rel     = done || !req[sel] || expired;
  assign busy    = state != ST_IDLE;
  // arbitration FSM, hold counter, last-grant pointer and registered mux output
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      sel      <= '0;
      gnt      <= '0;
      y        <= 1'b0;
      y_vld    <= 1'b0;
      hold_cnt <= '0;
      lg       <= SEL_W'(N_SRC - 1);
    end else begin
      case (state)
        ST_IDLE: begin
          y_vld <= 1'b0;
          if (any) begin
            sel      <= idx;
            gnt      <= N_SRC'(1) << idx;
            lg       <= idx;
            hold_cnt <= HOLD_W'(1);
            state    <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          y        <= d[sel];
          y_vld    <= 1'b1;
          hold_cnt <= &hold_cnt ? hold_cnt : hold_cnt + 1'b1;
          if (rel) begin
            gnt   <= '0;
            state <= ST_GAP;
          end
        end
        ST_GAP: begin
          y_vld    <= 1'b0;
          hold_cnt <= '0;
          state    <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mux8_rr_scheduler.sv
// tb_mux8_rr_scheduler: directed and randomized checks against a behavioural scheduler model
module tb_mux8_rr_scheduler;
  localparam int MAX_HOLD = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [7:0] req = '0;
  logic done = 1'b0;
  logic [7:0] d = '0;
  logic [2:0] sel;
  logic [7:0] gnt;
  logic y, y_vld, busy;
  int n_cmp = 0;
  int n_err = 0;
  int m_owner = -1;
  int m_held = 0;
  int m_last = 7;
  bit m_gap = 1'b0;
  logic [2:0] m_sel = '0;
  logic m_y = 1'b0;
  logic m_yv = 1'b0;

  mux8_rr_scheduler #(.MAX_HOLD(MAX_HOLD), .HOLD_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .done(done), .d(d),
    .sel(sel), .gnt(gnt), .y(y), .y_vld(y_vld), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] m_gnt();
    return m_owner >= 0 ? 8'(1) << m_owner : 8'd0;
  endfunction

  function automatic logic m_busy();
    return m_owner >= 0 || m_gap;
  endfunction

  task automatic model_update();
    if (!rst_n) begin
      m_owner = -1; m_gap = 0; m_last = 7; m_sel = 0; m_y = 0; m_yv = 0; m_held = 0;
    end else if (m_owner >= 0) begin
      m_y = d[m_owner];
      m_yv = 1;
      if (done || !req[m_owner] || (MAX_HOLD != 0 && m_held == MAX_HOLD)) begin
        m_owner = -1;
        m_gap = 1;
      end else m_held++;
    end else if (m_gap) begin
      m_gap = 0;
      m_yv = 0;
    end else begin
      m_yv = 0;
      for (int k = 1; k <= 8; k++)
        if (m_owner < 0 && req[(m_last + k) % 8]) m_owner = (m_last + k) % 8;
      if (m_owner >= 0) begin
        m_last = m_owner;
        m_sel = 3'(m_owner);
        m_held = 1;
      end
    end
  endtask

  task automatic tick();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_grant(output bit ok);
    logic [7:0] g0;
    ok = 0;
    for (int c = 0; c < 40 && !ok; c++) begin
      g0 = gnt;
      tick();
      ok = (gnt != 0) && (g0 == 0);
    end
  endtask

  task automatic go_idle();
    req = '0; done = 0;
    for (int c = 0; c < 4; c++) tick();
  endtask

  task automatic test_reset();
    rst_n = 0; req = 8'hFF; done = 0;
    tick(); tick();
    n_cmp++; if (gnt !== 8'h00) begin n_err++; $display("FAIL reset_gnt got=%h want=00", gnt); end
    n_cmp++; if (sel !== 3'd0) begin n_err++; $display("FAIL reset_sel got=%0d want=0", sel); end
    n_cmp++; if (y_vld !== 1'b0) begin n_err++; $display("FAIL reset_yvld got=%b want=0", y_vld); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b want=0", busy); end
    n_cmp++; if (y !== 1'b0) begin n_err++; $display("FAIL reset_y got=%b want=0", y); end
  endtask

  task automatic test_rr_order();
    logic [7:0] prev = '0;
    int hi = 0, lo = 0, ng = 0;
    rst_n = 1; req = 8'hFF; done = 0;
    for (int c = 0; c < 100 && ng < 9; c++) begin
      d = 8'($urandom);
      tick();
      n_cmp++;
      if ({gnt, sel, y, y_vld, busy} !== {m_gnt(), m_sel, m_y, m_yv, m_busy()}) begin
        n_err++;
        $display("FAIL rr_model got=%h/%0d/%b/%b/%b want=%h/%0d/%b/%b/%b", gnt, sel, y, y_vld, busy,
                 m_gnt(), m_sel, m_y, m_yv, m_busy());
      end
      if (gnt != 0 && prev == 0) begin
        n_cmp++;
        if (gnt !== 8'(1) << (ng % 8) || sel !== 3'(ng % 8)) begin
          n_err++; $display("FAIL rr_order grant#%0d got gnt=%h sel=%0d want idx=%0d", ng, gnt, sel, ng % 8);
        end
        if (ng > 0) begin
          n_cmp++;
          if (lo != 2) begin n_err++; $display("FAIL rr_gap got=%0d want=2", lo); end
        end
        ng++; hi = 1;
      end else if (gnt != 0) hi++;
      else if (prev != 0) begin
        n_cmp++;
        if (hi != MAX_HOLD) begin n_err++; $display("FAIL rr_hold got=%0d want=%0d", hi, MAX_HOLD); end
        lo = 1;
      end else lo++;
      prev = gnt;
    end
    n_cmp++;
    if (ng < 9) begin n_err++; $display("FAIL rr_timeout got=%0d grants want=9", ng); end
  endtask

  task automatic test_wrap();
    bit ok;
    go_idle();
    req = 8'h40;
    wait_grant(ok);
    n_cmp++; if (!ok || gnt !== 8'h40) begin n_err++; $display("FAIL wrap_g6 got=%h want=40", gnt); end
    req = 8'h03;
    wait_grant(ok);
    n_cmp++; if (!ok || gnt !== 8'h01 || sel !== 3'd0) begin n_err++; $display("FAIL wrap_g0 got=%h sel=%0d want=01 sel=0", gnt, sel); end
    wait_grant(ok);
    n_cmp++; if (!ok || gnt !== 8'h02 || sel !== 3'd1) begin n_err++; $display("FAIL wrap_g1 got=%h sel=%0d want=02 sel=1", gnt, sel); end
  endtask

  task automatic test_data_release();
    bit ok;
    go_idle();
    d = 8'b0000_1000; req = 8'h08;
    wait_grant(ok);
    n_cmp++; if (!ok || gnt !== 8'h08 || sel !== 3'd3 || y_vld !== 1'b0) begin n_err++; $display("FAIL dr_grant got=%h sel=%0d yv=%b want=08 sel=3 yv=0", gnt, sel, y_vld); end
    tick();
    n_cmp++; if (y !== 1'b1 || y_vld !== 1'b1 || gnt !== 8'h08) begin n_err++; $display("FAIL dr_sample got y=%b yv=%b gnt=%h want 1 1 08", y, y_vld, gnt); end
    done = 1; req = 8'h00;
    tick();
    done = 0;
    n_cmp++; if (gnt !== 8'h00 || busy !== 1'b1 || y_vld !== 1'b1) begin n_err++; $display("FAIL dr_release got gnt=%h busy=%b yv=%b want 00 1 1", gnt, busy, y_vld); end
    tick();
    n_cmp++; if (gnt !== 8'h00 || busy !== 1'b0 || y_vld !== 1'b0 || y !== 1'b1) begin n_err++; $display("FAIL dr_gap got gnt=%h busy=%b yv=%b y=%b want 00 0 0 1", gnt, busy, y_vld, y); end
    tick();
    n_cmp++; if (gnt !== 8'h00) begin n_err++; $display("FAIL dr_idle got=%h want=00", gnt); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    go_idle();
    req = 8'h20;
    wait_grant(ok);
    n_cmp++; if (!ok || gnt !== 8'h20) begin n_err++; $display("FAIL rm_grant got=%h want=20", gnt); end
    tick();
    rst_n = 0;
    tick();
    rst_n = 1;
    n_cmp++; if (gnt !== 8'h00 || busy !== 1'b0 || sel !== 3'd0 || y_vld !== 1'b0) begin n_err++; $display("FAIL rm_reset got gnt=%h busy=%b sel=%0d yv=%b want 00 0 0 0", gnt, busy, sel, y_vld); end
    tick();
    n_cmp++; if (gnt !== 8'h20 || sel !== 3'd5) begin n_err++; $display("FAIL rm_regrant got=%h sel=%0d want=20 sel=5", gnt, sel); end
    tick();
    n_cmp++; if (y_vld !== 1'b1) begin n_err++; $display("FAIL rm_latency got yv=%b want=1", y_vld); end
  endtask

  task automatic test_exhaustive();
    logic [7:0] dd;
    logic [7:0] want_g;
    int dv;
    done = 0; rst_n = 1;
    for (int s = 0; s < 8; s++) begin
      dv = 0;
      req = 8'(1) << s;
      want_g = req;
      for (int c = 0; c < 2000 && dv < 256; c++) begin
        dd = 8'(dv);
        d = dd;
        if (gnt == want_g) begin
          tick();
          n_cmp++;
          if (y !== dd[s] || y_vld !== 1'b1) begin
            n_err++; $display("FAIL exh s=%0d d=%h got y=%b yv=%b want y=%b yv=1", s, dd, y, y_vld, dd[s]);
          end
          dv++;
        end else tick();
      end
      n_cmp++;
      if (dv < 256) begin n_err++; $display("FAIL exh_timeout s=%0d got=%0d want=256", s, dv); end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 3000; c++) begin
      rst_n = ($urandom_range(0, 199) != 0);
      req = ($urandom_range(0, 3) == 0) ? 8'(1) << $urandom_range(0, 7) : 8'($urandom) & 8'($urandom);
      done = ($urandom_range(0, 7) == 0);
      d = 8'($urandom);
      tick();
      n_cmp++;
      if ({gnt, sel, y, y_vld, busy} !== {m_gnt(), m_sel, m_y, m_yv, m_busy()}) begin
        n_err++;
        $display("FAIL rand_model cyc=%0d got=%h/%0d/%b/%b/%b want=%h/%0d/%b/%b/%b", c, gnt, sel, y, y_vld, busy,
                 m_gnt(), m_sel, m_y, m_yv, m_busy());
      end
      n_cmp++;
      if (!$onehot0(gnt)) begin n_err++; $display("FAIL rand_onehot got=%h want=onehot0", gnt); end
    end
  endtask

  initial begin
    test_reset();
    test_rr_order();
    test_wrap();
    test_data_release();
    test_reset_mid();
    test_exhaustive();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
